// File: rtl/geiger_frame_scheduler_pkg.sv
// rtl/geiger_frame_scheduler_pkg.sv - shared frame layout, FSM states and byte mux for the geiger readout
package geiger_frame_scheduler_pkg;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    localparam int         FRAME_LEN     = 9;
    localparam int         FRAME_CNT_W   = 24;

    localparam logic [3:0] IDX_SYNC  = 4'd0;
    localparam logic [3:0] IDX_SEQ   = 4'd1;
    localparam logic [3:0] IDX_A_HI  = 4'd2;
    localparam logic [3:0] IDX_A_MID = 4'd3;
    localparam logic [3:0] IDX_A_LO  = 4'd4;
    localparam logic [3:0] IDX_B_HI  = 4'd5;
    localparam logic [3:0] IDX_B_MID = 4'd6;
    localparam logic [3:0] IDX_B_LO  = 4'd7;
    localparam logic [3:0] IDX_CHK   = 4'(FRAME_LEN - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    // Byte at a given frame position; chk is the running XOR of bytes 1..7.
    function automatic logic [7:0] frame_byte(
        input logic [3:0]             idx,
        input logic [7:0]             sync,
        input logic [7:0]             seq,
        input logic [FRAME_CNT_W-1:0] a,
        input logic [FRAME_CNT_W-1:0] b,
        input logic [7:0]             chk
    );
        case (idx)
            IDX_SYNC:  frame_byte = sync;
            IDX_SEQ:   frame_byte = seq;
            IDX_A_HI:  frame_byte = a[23:16];
            IDX_A_MID: frame_byte = a[15:8];
            IDX_A_LO:  frame_byte = a[7:0];
            IDX_B_HI:  frame_byte = b[23:16];
            IDX_B_MID: frame_byte = b[15:8];
            IDX_B_LO:  frame_byte = b[7:0];
            default:   frame_byte = chk;
        endcase
    endfunction

endpackage

// File: rtl/geiger_pulse_counter.sv
// rtl/geiger_pulse_counter.sv - tube input synchroniser, rising-edge detect and saturating counter
module geiger_pulse_counter #(
    parameter int CNT_W = 24
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             pulse,
    input  logic             clear,
    output logic [CNT_W-1:0] cnt
);

    // [0],[1] are the synchroniser pair, [2] is the previous synchronised level
    logic [2:0]       sync_q;
    logic             edge_det;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_nxt;

    assign edge_det = sync_q[1] & ~sync_q[2];
    assign cnt      = cnt_q;

    // An edge arriving on the clear cycle belongs to the new window.
    always_comb begin
        cnt_nxt = cnt_q;
        if (clear) begin
            cnt_nxt = {{(CNT_W-1){1'b0}}, edge_det};
        end else if (edge_det && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_nxt = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync_q <= '0;
            cnt_q  <= '0;
        end else begin
            sync_q <= {sync_q[1:0], pulse};
            cnt_q  <= cnt_nxt;
        end
    end

endmodule

// File: rtl/geiger_frame_scheduler.sv
// rtl/geiger_frame_scheduler.sv - window timer, count snapshot and 9-byte frame serialiser
module geiger_frame_scheduler
    import geiger_frame_scheduler_pkg::*;
#(
    parameter int         WINDOW_TICKS = 1000000,
    parameter int         CNT_W        = FRAME_CNT_W,
    parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEF
) (
    input  logic       CLK_1MHZ,
    input  logic       NSYSRESET,
    input  logic       GEIGER_A,
    input  logic       GEIGER_B,
    output logic [7:0] D,
    output logic       BYTE_VALID,
    input  logic       BYTE_READY,
    output logic       BUSY,
    output logic       OVERRUN
);

    localparam int TW = $clog2(WINDOW_TICKS);

    state_t           state_q, state_d;
    logic [TW-1:0]    timer_q;
    logic             wend;
    logic             clear_cnt;
    logic [CNT_W-1:0] cnt_a, cnt_b;
    logic [CNT_W-1:0] snap_a_q, snap_a_d, snap_b_q, snap_b_d;
    logic [3:0]       idx_q, idx_d, idx_inc;
    logic [7:0]       seq_q, seq_d, chk_q, chk_d, d_q, d_d, next_byte;
    logic             valid_q, valid_d, ovr_q, ovr_d;

    geiger_pulse_counter #(.CNT_W(CNT_W)) u_cnt_a (
        .clk    (CLK_1MHZ),
        .resetn (NSYSRESET),
        .pulse  (GEIGER_A),
        .clear  (clear_cnt),
        .cnt    (cnt_a)
    );

    geiger_pulse_counter #(.CNT_W(CNT_W)) u_cnt_b (
        .clk    (CLK_1MHZ),
        .resetn (NSYSRESET),
        .pulse  (GEIGER_B),
        .clear  (clear_cnt),
        .cnt    (cnt_b)
    );

    assign wend      = (timer_q == TW'(WINDOW_TICKS - 1));
    assign idx_inc   = idx_q + 4'd1;
    assign next_byte = frame_byte(idx_inc, SYNC_BYTE, seq_q, snap_a_q, snap_b_q, chk_q);

    assign D          = d_q;
    assign BYTE_VALID = valid_q;
    assign BUSY       = (state_q == ST_SEND);
    assign OVERRUN    = ovr_q;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        seq_d     = seq_q;
        chk_d     = chk_q;
        d_d       = d_q;
        valid_d   = valid_q;
        snap_a_d  = snap_a_q;
        snap_b_d  = snap_b_q;
        clear_cnt = 1'b0;
        ovr_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (wend) begin
                    clear_cnt = 1'b1;
                    snap_a_d  = cnt_a;
                    snap_b_d  = cnt_b;
                    idx_d     = IDX_SYNC;
                    chk_d     = 8'h00;
                    d_d       = SYNC_BYTE;
                    valid_d   = 1'b1;
                    state_d   = ST_SEND;
                end
            end
            ST_SEND: begin
                // Window ends mid-frame: counters keep running into the next window.
                ovr_d = wend;
                if (BYTE_READY) begin
                    if (idx_q == IDX_CHK) begin
                        valid_d = 1'b0;
                        seq_d   = seq_q + 8'd1;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d = idx_inc;
                        d_d   = next_byte;
                        if (idx_inc != IDX_CHK) begin
                            chk_d = chk_q ^ next_byte;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK_1MHZ) begin
        if (!NSYSRESET) begin
            state_q  <= ST_IDLE;
            timer_q  <= '0;
            idx_q    <= '0;
            seq_q    <= '0;
            chk_q    <= '0;
            d_q      <= '0;
            valid_q  <= 1'b0;
            ovr_q    <= 1'b0;
            snap_a_q <= '0;
            snap_b_q <= '0;
        end else begin
            state_q  <= state_d;
            timer_q  <= wend ? '0 : timer_q + TW'(1);
            idx_q    <= idx_d;
            seq_q    <= seq_d;
            chk_q    <= chk_d;
            d_q      <= d_d;
            valid_q  <= valid_d;
            ovr_q    <= ovr_d;
            snap_a_q <= snap_a_d;
            snap_b_q <= snap_b_d;
        end
    end

endmodule

// File: tb/tb_geiger_frame_scheduler.sv
// tb/tb_geiger_frame_scheduler.sv - self-checking bench for geiger_frame_scheduler
module tb_geiger_frame_scheduler;

    localparam int W = 100;

    logic       CLK_1MHZ = 1'b0;
    logic       NSYSRESET, GEIGER_A, GEIGER_B, BYTE_READY;
    logic       BYTE_VALID, BUSY, OVERRUN;
    logic [7:0] D;

    int errors = 0;
    int checks = 0;

    geiger_frame_scheduler #(.WINDOW_TICKS(W)) dut (
        .CLK_1MHZ   (CLK_1MHZ),
        .NSYSRESET  (NSYSRESET),
        .GEIGER_A   (GEIGER_A),
        .GEIGER_B   (GEIGER_B),
        .D          (D),
        .BYTE_VALID (BYTE_VALID),
        .BYTE_READY (BYTE_READY),
        .BUSY       (BUSY),
        .OVERRUN    (OVERRUN)
    );

    always #5 CLK_1MHZ = ~CLK_1MHZ;

    // model state: describes the cycle currently in progress
    int          cyc = 0;
    int          m_t = 0;
    int          m_idx = 0;
    logic [23:0] m_a = '0, m_b = '0;
    logic [7:0]  m_seq = '0;
    bit          m_busy = 0, m_ovr = 0;
    logic [7:0]  exp_frame [9];
    int          qa[$], qb[$];

    logic [7:0]  cap [9], last_frame [9];
    int          cap_n = 0, frames_done = 0, stall_cnt = 0, ovr_cnt = 0;
    int          busy_run = 0, last_busy = 0;
    bit          mon_en = 0, prev_idle = 0;
    logic [7:0]  prev_d = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge CLK_1MHZ) begin
        bit ea, eb, wend, busy_n, ovr_n;
        int idx_n;
        if (mon_en) begin
            chk("valid", BYTE_VALID, m_busy);
            chk("busy", BUSY, m_busy);
            chk("overrun", OVERRUN, m_ovr);
            if (m_busy) chk("byte", D, exp_frame[m_idx]);
            if (!BYTE_VALID && prev_idle) chk("d_hold", D, prev_d);
        end
        prev_idle = !BYTE_VALID && NSYSRESET;
        prev_d = D;
        if (OVERRUN) ovr_cnt++;
        if (BUSY) busy_run++;
        else if (busy_run != 0) begin last_busy = busy_run; busy_run = 0; end
        if (BYTE_VALID && !BYTE_READY && NSYSRESET) stall_cnt++;
        if (BYTE_VALID && BYTE_READY && NSYSRESET) begin
            cap[cap_n] = D;
            cap_n++;
            if (cap_n == 9) begin last_frame = cap; frames_done++; cap_n = 0; end
        end

        if (!NSYSRESET) begin
            m_t = 0; m_a = '0; m_b = '0; m_seq = '0; m_busy = 0; m_idx = 0; m_ovr = 0;
            qa.delete(); qb.delete(); cap_n = 0;
        end else begin
            ea = (qa.size() != 0 && qa[0] == cyc);
            eb = (qb.size() != 0 && qb[0] == cyc);
            if (ea) void'(qa.pop_front());
            if (eb) void'(qb.pop_front());
            wend = (m_t == W - 1);
            ovr_n = wend && m_busy;
            busy_n = m_busy;
            idx_n = m_idx;
            if (m_busy && BYTE_READY) begin
                if (m_idx == 8) begin busy_n = 0; m_seq++; end
                else idx_n = m_idx + 1;
            end
            if (wend && !m_busy) begin
                exp_frame[0] = 8'hA5;     exp_frame[1] = m_seq;
                exp_frame[2] = m_a[23:16]; exp_frame[3] = m_a[15:8]; exp_frame[4] = m_a[7:0];
                exp_frame[5] = m_b[23:16]; exp_frame[6] = m_b[15:8]; exp_frame[7] = m_b[7:0];
                exp_frame[8] = 8'h00;
                for (int i = 1; i < 8; i++) exp_frame[8] ^= exp_frame[i];
                m_a = ea ? 24'd1 : 24'd0;
                m_b = eb ? 24'd1 : 24'd0;
                busy_n = 1;
                idx_n = 0;
            end else begin
                if (ea && m_a != 24'hFFFFFF) m_a++;
                if (eb && m_b != 24'hFFFFFF) m_b++;
            end
            m_t = (m_t == W - 1) ? 0 : m_t + 1;
            m_busy = busy_n;
            m_idx = idx_n;
            m_ovr = ovr_n;
        end
        cyc++;
    end

    task automatic tick();
        @(posedge CLK_1MHZ);
        #2;
    endtask

    // an input rise is counted two clocks later (synchroniser latency)
    task automatic pulse(input bit tube_b);
        if (tube_b) begin GEIGER_B = 1'b1; qb.push_back(cyc + 2); end
        else        begin GEIGER_A = 1'b1; qa.push_back(cyc + 2); end
        tick();
        GEIGER_A = 1'b0;
        GEIGER_B = 1'b0;
        tick();
    endtask

    task automatic wait_frames(input int target);
        int k = 0;
        while (frames_done < target && k < 2000) begin tick(); k++; end
        chk("frame_timeout", frames_done >= target, 1);
    endtask

    task automatic wait_send(input int idx);
        int k = 0;
        while (!(m_busy && m_idx == idx) && k < 1000) begin tick(); k++; end
        chk("send_timeout", m_busy && m_idx == idx, 1);
    endtask

    task automatic wait_idle_t(input int t);
        int k = 0;
        while (!(!m_busy && m_t == t) && k < 1000) begin tick(); k++; end
        chk("timer_timeout", !m_busy && m_t == t, 1);
    endtask

    task automatic check_frame(input string name, input logic [71:0] e);
        for (int i = 0; i < 9; i++) chk(name, last_frame[i], e[71-8*i -: 8]);
    endtask

    initial begin
        int c0;
        NSYSRESET = 1'b0; GEIGER_A = 1'b0; GEIGER_B = 1'b0; BYTE_READY = 1'b1;
        repeat (3) tick();
        chk("reset_d", D, 8'h00);
        chk("reset_valid", BYTE_VALID, 0);
        chk("reset_busy", BUSY, 0);
        chk("reset_overrun", OVERRUN, 0);
        NSYSRESET = 1'b1;
        mon_en = 1;

        // basic frame
        repeat (5) pulse(0);
        repeat (3) pulse(1);
        wait_frames(1);
        tick();
        check_frame("basic", 72'hA5_00_00_00_05_00_00_03_06);
        chk("busy_len", last_busy, 9);
        wait_frames(2);
        chk("seq_next", last_frame[1], 8'h01);

        // backpressure on byte 3
        pulse(1);
        wait_send(3);
        stall_cnt = 0;
        BYTE_READY = 1'b0;
        repeat (4) tick();
        BYTE_READY = 1'b1;
        wait_frames(3);
        check_frame("backpressure", 72'hA5_02_00_00_00_00_00_01_03);
        chk("stall_cycles", stall_cnt, 4);

        // overrun: long stall across a window end
        wait_send(0);
        BYTE_READY = 1'b0;
        c0 = cyc;
        ovr_cnt = 0;
        pulse(0); pulse(0); pulse(1); pulse(1);
        while (cyc < c0 + 110) tick();
        pulse(0);
        while (cyc < c0 + 150) tick();
        BYTE_READY = 1'b1;
        wait_frames(4);
        chk("overrun_pulses", ovr_cnt, 1);
        wait_frames(5);
        check_frame("after_overrun", 72'hA5_04_00_00_03_00_00_02_05);

        // edge detected on the window-end cycle
        wait_idle_t(W - 3);
        pulse(0);
        wait_frames(6);
        chk("boundary_excluded", last_frame[4], 8'h00);
        wait_frames(7);
        chk("boundary_next", last_frame[4], 8'h01);

        // saturation
        wait_idle_t(20);
        force dut.u_cnt_a.cnt_q = 24'hFFFFFE;
        m_a = 24'hFFFFFE;
        tick();
        release dut.u_cnt_a.cnt_q;
        repeat (3) pulse(0);
        wait_frames(8);
        check_frame("saturation", 72'hA5_07_FF_FF_FF_00_00_00_F8);

        // reset mid-frame; a rise during reset must not count
        pulse(1);
        wait_send(4);
        NSYSRESET = 1'b0;
        GEIGER_A = 1'b1;
        tick();
        NSYSRESET = 1'b1;
        GEIGER_A = 1'b0;
        chk("rst_mid_valid", BYTE_VALID, 0);
        chk("rst_mid_d", D, 8'h00);
        pulse(0); pulse(0);
        wait_frames(9);
        check_frame("after_reset", 72'hA5_00_00_00_02_00_00_00_02);

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
